// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI4 write-burst master:
//   wr_state_e      - write-master FSM states (IDLE, ADDR, DATA, RESP)
//   BURST_INCR      - AWBURST encoding for incrementing bursts
//   RESP_*          - BRESP encodings
//   size_from_bytes - AWSIZE encoding (log2 of bytes per beat)
// -----------------------------------------------------------------------------
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AWSIZE is log2(bytes per beat). Only powers of two from 1 to 128 bytes
  // are legal; anything else maps to 0.
  function automatic logic [2:0] size_from_bytes(input int unsigned nbytes);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (nbytes == (32'd1 << i)) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi_wr_master.sv
// -----------------------------------------------------------------------------
// axi_wr_master
// Single-outstanding AXI4 write-burst master. One command (address, beat count,
// ID) is accepted, the AW beat is issued, the caller's data stream is passed
// through onto W, and the B response is reported back as a one-cycle pulse.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_addr/cmd_len/cmd_id          burst start address, AWLEN, AWID
//   wd_valid/wd_ready                data-beat handshake from the command source
//   wd_data/wd_strb                  beat payload and byte enables
//   done_valid/done_resp             completion pulse and its response code
//   AW*, W*, B*                      AXI4 write address / data / response
//   o_dbg_state                      current FSM state (wr_state_e encoding)
//
// Handshakes: every channel uses strict valid/ready semantics. A transfer
// happens on a rising edge where valid and ready are both high; a raised valid
// is never withdrawn and its payload never changes until that transfer, except
// WVALID, which mirrors wd_valid and therefore follows the source's own stalls.
// -----------------------------------------------------------------------------
module axi_wr_master
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,

  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  input  logic [STRB_WIDTH-1:0] wd_strb,

  output logic                  done_valid,
  output logic [1:0]            done_resp,

  output logic [ID_WIDTH-1:0]   AWID,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic [3:0]            AWREGION,
  output logic                  AWVALID,
  input  logic                  AWREADY,

  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,

  input  logic [ID_WIDTH-1:0]   BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,

  output logic [1:0]            o_dbg_state
);

  localparam logic [2:0] AW_SIZE = size_from_bytes(STRB_WIDTH);

  wr_state_e             r_state;
  wr_state_e             w_next_state;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [ID_WIDTH-1:0]   r_id;
  logic [7:0]            r_beat_cnt;
  logic                  r_cmd_ready;
  logic                  r_done_valid;
  logic [1:0]            r_done_resp;

  logic                  w_cmd_hs;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_last;
  logic                  w_in_data;

  assign w_in_data = (r_state == DATA);
  assign w_last    = (r_beat_cnt == r_len);

  // ---------------------------------------------------------------------------
  // Next-state logic and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_cmd_hs     = 1'b0;
    w_aw_hs      = 1'b0;
    w_w_hs       = 1'b0;
    w_b_hs       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_hs     = 1'b1;
          w_next_state = ADDR;
        end
      end
      ADDR: begin
        if (AWREADY) begin
          w_aw_hs      = 1'b1;
          w_next_state = DATA;
        end
      end
      DATA: begin
        if (wd_valid && WREADY) begin
          w_w_hs = 1'b1;
          if (w_last) w_next_state = RESP;
        end
      end
      RESP: begin
        if (BVALID) begin
          w_b_hs       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, command holding registers, beat counter, completion
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_id         <= '0;
      r_beat_cnt   <= '0;
      r_cmd_ready  <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_resp  <= '0;
    end else begin
      r_state <= w_next_state;

      // cmd_ready is registered so that it is low in the first cycle out of
      // reset and in the cycle carrying done_valid: it only rises after a full
      // cycle spent in IDLE, and drops on the edge that accepts a command.
      r_cmd_ready <= (r_state == IDLE) && (w_next_state == IDLE);

      if (w_cmd_hs) begin
        r_addr <= cmd_addr;
        r_len  <= cmd_len;
        r_id   <= cmd_id;
      end

      // The counter stops at the last beat instead of stepping past it, so a
      // 256-beat burst ends with the counter at 255 rather than wrapping to 0.
      if (w_aw_hs) begin
        r_beat_cnt <= '0;
      end else if (w_w_hs && !w_last) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end

      r_done_valid <= w_b_hs;
      if (w_b_hs) begin
        r_done_resp <= (BID == r_id) ? BRESP : RESP_SLVERR;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready   = r_cmd_ready;
  assign done_valid  = r_done_valid;
  assign done_resp   = r_done_resp;

  assign AWVALID     = (r_state == ADDR);
  assign AWID        = r_id;
  assign AWADDR      = r_addr;
  assign AWLEN       = r_len;
  assign AWSIZE      = AW_SIZE;
  assign AWBURST     = BURST_INCR;
  assign AWREGION    = 4'd0;

  // W is a combinational pass-through of the source stream, gated so that
  // nothing appears on W before the AW handshake or after the last beat.
  assign WVALID      = w_in_data && wd_valid;
  assign WDATA       = w_in_data ? wd_data : '0;
  assign WSTRB       = w_in_data ? wd_strb : '0;
  assign WLAST       = w_in_data && w_last;
  assign wd_ready    = w_in_data && WREADY;

  assign BREADY      = (r_state == RESP);

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_wr_master.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_master
// Randomised bench for axi_wr_master: a directed sequence plus random bursts,
// a responsive AXI slave model, and a transaction-level reference model that
// checks every DUT output on every falling edge.
// -----------------------------------------------------------------------------
module tb_axi_wr_master;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int CW  = DW + SW;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_valid, cmd_ready;
  logic [AW-1:0]  cmd_addr;
  logic [7:0]     cmd_len;
  logic [IDW-1:0] cmd_id;
  logic           wd_valid, wd_ready;
  logic [DW-1:0]  wd_data;
  logic [SW-1:0]  wd_strb;
  logic           done_valid;
  logic [1:0]     done_resp;
  logic [IDW-1:0] AWID;
  logic [AW-1:0]  AWADDR;
  logic [7:0]     AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic [3:0]     AWREGION;
  logic           AWVALID, AWREADY;
  logic [DW-1:0]  WDATA;
  logic [SW-1:0]  WSTRB;
  logic           WLAST, WVALID, WREADY;
  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID, BREADY;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  axi_wr_master #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .done_valid(done_valid), .done_resp(done_resp),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWREGION(AWREGION), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [CW-1:0] exp_q[$];   // {strb, data} of every beat still to appear on W

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave configuration (set by the sequencer before each burst)
  // ---------------------------------------------------------------------------
  int             cfg_aw_stall = 0;
  int             cfg_aw_prob  = 100;
  int             cfg_w_prob   = 100;
  int             cfg_b_delay  = 0;
  int             cfg_spur     = 0;
  logic [IDW-1:0] cfg_bid      = '0;
  logic [1:0]     cfg_bresp    = '0;

  // Slave: AWREADY held low for cfg_aw_stall AWVALID cycles, random WREADY,
  // B returned after the last W beat, spurious BVALID when nothing is due.
  initial begin : slave
    bit s_aw_hs, s_aw_wait, s_wl_hs, s_b_hs, pending;
    int aw_seen, b_wait;
    pending = 1'b0; aw_seen = 0; b_wait = 0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BID = '0; BRESP = '0;
    forever begin
      @(negedge clk);
      s_aw_hs   = AWVALID && AWREADY;
      s_aw_wait = AWVALID && !AWREADY;
      s_wl_hs   = WVALID && WREADY && WLAST;
      s_b_hs    = BVALID && BREADY;
      @(posedge clk); #1;
      if (!rst_n) begin
        pending = 1'b0;
        aw_seen = 0;
      end else begin
        if (s_aw_hs) aw_seen = 0;
        else if (s_aw_wait) aw_seen++;
        if (s_b_hs) pending = 1'b0;
        if (s_wl_hs) begin
          pending = 1'b1;
          b_wait  = cfg_b_delay;
        end
      end
      AWREADY = (aw_seen >= cfg_aw_stall) && ($urandom_range(0, 99) < cfg_aw_prob);
      WREADY  = ($urandom_range(0, 99) < cfg_w_prob);
      if (pending) begin
        if (b_wait > 0) begin
          b_wait--;
          BVALID = 1'b0;
        end else begin
          BVALID = 1'b1;
          BID    = cfg_bid;
          BRESP  = cfg_bresp;
        end
      end else begin
        BVALID = ($urandom_range(0, 99) < cfg_spur);
        BID    = IDW'($urandom);
        BRESP  = 2'($urandom);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model + compare process. The model tracks the burst at
  // transaction level: is one in flight, has its address gone out, how many
  // beats have gone out, has the response come back. Checks run on the
  // falling edge; the model then advances by whatever transfers the coming
  // rising edge will perform.
  // ---------------------------------------------------------------------------
  bit             m_busy = 1'b0, m_aw_done = 1'b0, m_w_done = 1'b0, m_done_due = 1'b0;
  int             m_beats = 0, m_len = 0, m_idle = 0;
  logic [AW-1:0]  m_addr = '0;
  logic [IDW-1:0] m_id = '0;
  logic [1:0]     m_resp = '0;

  // Observations for the sequencer's literal checks (actual DUT behaviour).
  int             obs_w_hs = 0, obs_wlast = 0, obs_aw_cycles = 0;
  logic [AW-1:0]  obs_awaddr = '0;
  logic [7:0]     obs_awlen = '0;
  logic [2:0]     obs_awsize = '0;
  logic [1:0]     obs_awburst = '0;

  always @(negedge clk) begin : compare
    bit e_cmd_ready, e_awvalid, e_indata, e_wvalid, e_wd_ready, e_bready;
    if (!rst_n) begin
      m_busy = 1'b0; m_aw_done = 1'b0; m_w_done = 1'b0; m_done_due = 1'b0;
      m_idle = 0; m_beats = 0;
      exp_q.delete();
    end
    e_cmd_ready = !m_busy && (m_idle >= 1);
    e_awvalid   = m_busy && !m_aw_done;
    e_indata    = m_busy && m_aw_done && !m_w_done;
    e_wvalid    = e_indata && wd_valid;
    e_wd_ready  = e_indata && WREADY;
    e_bready    = m_busy && m_w_done;

    chk("cmd_ready",  CW'(cmd_ready),  CW'(e_cmd_ready));
    chk("awvalid",    CW'(AWVALID),    CW'(e_awvalid));
    chk("wvalid",     CW'(WVALID),     CW'(e_wvalid));
    chk("wd_ready",   CW'(wd_ready),   CW'(e_wd_ready));
    chk("bready",     CW'(BREADY),     CW'(e_bready));
    chk("done_valid", CW'(done_valid), CW'(m_done_due));
    if (m_done_due) chk("done_resp", CW'(done_resp), CW'(m_resp));
    if (e_awvalid) begin
      chk("awaddr",   CW'(AWADDR),   CW'(m_addr));
      chk("awlen",    CW'(AWLEN),    CW'(m_len));
      chk("awid",     CW'(AWID),     CW'(m_id));
      chk("awsize",   CW'(AWSIZE),   CW'($clog2(SW)));
      chk("awburst",  CW'(AWBURST),  CW'(2'b01));
      chk("awregion", CW'(AWREGION), CW'(4'd0));
    end
    if (e_wvalid) begin
      chk("wlast", CW'(WLAST), CW'(m_beats == m_len));
      if (exp_q.size() == 0) chk("w_beat_unexpected", CW'(1), CW'(0));
      else chk("w_beat", {WSTRB, WDATA}, exp_q[0]);
    end

    // Observations of the DUT itself
    if (AWVALID) obs_aw_cycles++;
    if (AWVALID && AWREADY) begin
      obs_awaddr = AWADDR; obs_awlen = AWLEN; obs_awsize = AWSIZE; obs_awburst = AWBURST;
    end
    if (WVALID && WREADY) begin
      obs_w_hs++;
      if (WLAST) obs_wlast++;
    end

    // Advance the model across the coming rising edge
    if (rst_n) begin
      m_done_due = 1'b0;
      if (e_bready && BVALID) begin
        m_done_due = 1'b1;
        m_resp     = (BID == m_id) ? BRESP : 2'b10;
        m_busy     = 1'b0;
        m_idle     = 0;
      end else if (!m_busy) begin
        if (e_cmd_ready && cmd_valid) begin
          m_busy = 1'b1; m_aw_done = 1'b0; m_w_done = 1'b0; m_beats = 0;
          m_addr = cmd_addr; m_len = int'(cmd_len); m_id = cmd_id;
        end else if (m_idle < 2) begin
          m_idle++;
        end
      end
      if (e_awvalid && AWREADY) m_aw_done = 1'b1;
      if (e_wvalid && WREADY) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_beats == m_len) m_w_done = 1'b1;
        else m_beats++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Runs one burst. abort_at >= 0 asserts rst_n after that many beats have
  // been transferred and returns at once (got_done = 0).
  task automatic send_burst(input logic [AW-1:0] addr, input int len,
                            input logic [IDW-1:0] id, input logic [IDW-1:0] bid,
                            input logic [1:0] bresp, input int aw_stall,
                            input int w_prob, input int gap, input int abort_at,
                            output logic [1:0] resp_got, output bit got_done);
    logic [CW-1:0] drv_q[$];
    bit hs;
    int budget, k;
    resp_got = '0;
    got_done = 1'b0;
    assert ((int'(addr[11:0]) + (len + 1) * SW) <= 4096)
      else $error("illegal command crossing a 4KB boundary: addr 0x%0h len %0d", addr, len);
    cfg_aw_stall = aw_stall; cfg_w_prob = w_prob; cfg_bid = bid; cfg_bresp = bresp;
    obs_w_hs = 0; obs_wlast = 0; obs_aw_cycles = 0;
    for (int i = 0; i <= len; i++) begin
      drv_q.push_back({SW'($urandom), DW'({$urandom, $urandom})});
      exp_q.push_back(drv_q[i]);
    end

    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 8'(len); cmd_id = id;
    hs = 1'b0; budget = 200;
    while (!hs && budget > 0) begin
      @(negedge clk); hs = cmd_ready;
      @(posedge clk); #1;
      budget--;
    end
    cmd_valid = 1'b0;
    chk("cmd_accept_timeout", CW'(hs), CW'(1));

    k = 0; budget = 10000;
    while (k <= len && budget > 0) begin
      wd_valid = ($urandom_range(0, 99) >= gap);
      wd_data  = drv_q[k][DW-1:0];
      wd_strb  = drv_q[k][CW-1:DW];
      @(negedge clk); hs = wd_valid && wd_ready;
      @(posedge clk); #1;
      if (hs) k++;
      budget--;
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        wd_valid = 1'b0;
        return;
      end
    end
    wd_valid = 1'b0;
    chk("data_timeout", CW'(k), CW'(len + 1));

    budget = 500;
    while (!got_done && budget > 0) begin
      @(negedge clk);
      if (done_valid) begin
        got_done = 1'b1;
        resp_got = done_resp;
        chk("cmd_ready_during_done", CW'(cmd_ready), CW'(0));
      end
      @(posedge clk); #1;
      budget--;
    end
    chk("done_timeout", CW'(got_done), CW'(1));
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  initial begin : sequencer
    logic [1:0] resp;
    bit got;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", CW'(cmd_ready), CW'(0));
    chk("rst_awvalid",   CW'(AWVALID),   CW'(0));
    chk("rst_awaddr",    CW'(AWADDR),    CW'(0));
    chk("rst_done_resp", CW'(done_resp), CW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single beat
    send_burst(32'h1000, 0, 4'd3, 4'd3, 2'b00, 0, 100, 0, -1, resp, got);
    chk("t1_awlen",   CW'(obs_awlen),   CW'(0));
    chk("t1_awsize",  CW'(obs_awsize),  CW'(3));
    chk("t1_awaddr",  CW'(obs_awaddr),  CW'(32'h1000));
    chk("t1_awburst", CW'(obs_awburst), CW'(1));
    chk("t1_w_hs",    CW'(obs_w_hs),    CW'(1));
    chk("t1_wlast",   CW'(obs_wlast),   CW'(1));
    chk("t1_resp",    CW'(resp),        CW'(0));

    // 4 beats, AWREADY low for 5 AWVALID cycles, WREADY toggling
    send_burst(32'h2040, 3, 4'd7, 4'd7, 2'b00, 5, 50, 0, -1, resp, got);
    chk("t2_aw_cycles", CW'(obs_aw_cycles), CW'(6));
    chk("t2_w_hs",      CW'(obs_w_hs),      CW'(4));
    chk("t2_wlast",     CW'(obs_wlast),     CW'(1));
    chk("t2_resp",      CW'(resp),          CW'(0));

    // 256 beats with source gaps
    send_burst(32'h0003_0000, 255, 4'd1, 4'd1, 2'b00, 0, 70, 30, -1, resp, got);
    chk("t3_awlen", CW'(obs_awlen), CW'(255));
    chk("t3_w_hs",  CW'(obs_w_hs),  CW'(256));
    chk("t3_wlast", CW'(obs_wlast), CW'(1));
    chk("t3_resp",  CW'(resp),      CW'(0));

    // BID mismatch
    send_burst(32'h4000, 1, 4'd5, 4'd6, 2'b00, 0, 100, 0, -1, resp, got);
    chk("t4_resp_mismatch", CW'(resp), CW'(2'b10));

    // DECERR, then a back-to-back command
    cfg_b_delay = 3;
    send_burst(32'h5000, 2, 4'd9, 4'd9, 2'b11, 0, 100, 0, -1, resp, got);
    chk("t5_resp_decerr", CW'(resp), CW'(2'b11));
    cfg_b_delay = 0;
    send_burst(32'h5100, 1, 4'd2, 4'd2, 2'b01, 0, 100, 0, -1, resp, got);
    chk("t5_b2b_resp", CW'(resp), CW'(2'b01));

    // Reset during beat 2 of an 8-beat burst
    send_burst(32'h6000, 7, 4'd4, 4'd4, 2'b00, 0, 100, 0, 2, resp, got);
    @(negedge clk);
    chk("t6_rst_awvalid",   CW'(AWVALID),    CW'(0));
    chk("t6_rst_wvalid",    CW'(WVALID),     CW'(0));
    chk("t6_rst_bready",    CW'(BREADY),     CW'(0));
    chk("t6_rst_done",      CW'(done_valid), CW'(0));
    chk("t6_rst_cmd_ready", CW'(cmd_ready),  CW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rel_cmd_ready0", CW'(cmd_ready), CW'(0));
    @(negedge clk);
    chk("t6_rel_cmd_ready1", CW'(cmd_ready), CW'(1));
    @(posedge clk); #1;
    send_burst(32'h6000, 7, 4'd4, 4'd4, 2'b00, 0, 100, 0, -1, resp, got);
    chk("t6_after_w_hs", CW'(obs_w_hs), CW'(8));
    chk("t6_after_resp", CW'(resp),     CW'(0));

    // Random bursts, with spurious BVALID while no response is due
    cfg_spur = 20;
    for (int n = 0; n < 25; n++) begin
      int len, off, stall;
      logic [IDW-1:0] id, bid;
      logic [1:0] br;
      logic [AW-1:0] addr;
      len   = $urandom_range(0, 40);
      off   = $urandom_range(0, 511 - len);
      addr  = (AW'($urandom_range(0, 255)) << 12) | AW'(off * SW);
      id    = IDW'($urandom);
      bid   = ($urandom_range(0, 3) == 0) ? IDW'($urandom) : id;
      br    = 2'($urandom);
      stall = $urandom_range(0, 4);
      cfg_b_delay = $urandom_range(0, 3);
      cfg_aw_prob = $urandom_range(40, 100);
      send_burst(addr, len, id, bid, br, stall, $urandom_range(30, 100),
                 $urandom_range(0, 40), -1, resp, got);
      chk("rand_w_hs", CW'(obs_w_hs), CW'(len + 1));
      chk("rand_resp", CW'(resp), CW'((bid == id) ? br : 2'b10));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "time limit");
  end

endmodule
